// File: rtl/hamming74_encoder.sv
// hamming74_encoder: streaming Hamming(7,4) encoder for the transmit side.
// Each accepted byte becomes two 7-bit codewords: low nibble first, then high.
// Codeword layout: [6:3] data nibble, [2:0] parity bits chosen so the receive
// syndrome s0=c5^c4^c3^c0, s1=c6^c5^c4^c1, s2=c6^c5^c3^c2 is zero.
// Optional error injection for decoder bring-up: define HAMMING_ERR_INJECT_EN.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high. valid never depends on ready; once
// out_valid is high, out_code/out_last hold until the transfer.
module hamming74_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  output logic             out_last,
  output logic [CNT_W-1:0] cw_count,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic             inj_en,
  input  logic [2:0]       inj_pos,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] hi_nib;
  logic       in_hs;
  logic       out_hs;

  // Parity for one nibble; data bits pass straight through to [6:3].
  function automatic logic [6:0] encode_nibble(input logic [3:0] d);
    logic [6:0] c;
    c[6:3] = d;
    c[0]   = d[2] ^ d[1] ^ d[0];
    c[1]   = d[3] ^ d[2] ^ d[1];
    c[2]   = d[3] ^ d[2] ^ d[0];
    return c;
  endfunction

`ifdef HAMMING_ERR_INJECT_EN
  logic [6:0] inj_mask;

  // Single-bit flip mask, sampled only on the edge a codeword is loaded.
  always_comb begin
    inj_mask = 7'h00;
    if (inj_en && (inj_pos != 3'd7))
      inj_mask = 7'h01 << inj_pos;
  end

  function automatic logic [6:0] load_code(input logic [3:0] d, input logic [6:0] mask);
    return encode_nibble(d) ^ mask;
  endfunction
`else
  function automatic logic [6:0] load_code(input logic [3:0] d, input logic [6:0] mask);
    return encode_nibble(d) | (mask & 7'h00);
  endfunction

  logic [6:0] inj_mask;

  // No injection in this build: the mask is a constant zero.
  always_comb begin
    inj_mask = 7'h00;
  end
`endif

  // in_ready is forced low while reset is asserted so nothing is accepted
  // on a reset edge; otherwise it frees up as soon as the last codeword leaves.
  assign in_ready  = reset_n & ((state == ST_EMPTY) | ((state == ST_HIGH) & out_ready));
  assign out_valid = (state != ST_EMPTY);
  assign out_last  = (state == ST_HIGH);
  assign state_dbg = state;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Byte-splitting FSM, codeword register and transfer counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_EMPTY;
      out_code <= 7'h00;
      hi_nib   <= 4'h0;
      cw_count <= '0;
    end else begin
      if (out_hs)
        cw_count <= cw_count + 1'b1;
      case (state)
        ST_EMPTY: begin
          if (in_hs) begin
            state    <= ST_LOW;
            out_code <= load_code(in_data[3:0], inj_mask);
            hi_nib   <= in_data[7:4];
          end
        end
        ST_LOW: begin
          if (out_hs) begin
            state    <= ST_HIGH;
            out_code <= load_code(hi_nib, inj_mask);
          end
        end
        ST_HIGH: begin
          if (out_hs) begin
            if (in_hs) begin
              state    <= ST_LOW;
              out_code <= load_code(in_data[3:0], inj_mask);
              hi_nib   <= in_data[7:4];
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming74_encoder.sv
// Directed bench for hamming74_encoder. Expected codewords are hand-computed
// from the encode rule; syndrome and single-error correction use the
// receive-side equations. A second instance with CNT_W=4 checks counter wrap.
module tb_hamming74_encoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [6:0]  out_code;
  logic        out_last;
  logic [15:0] cw_count;
  logic [1:0]  state_dbg;

  logic        in_ready_w4;
  logic        out_valid_w4;
  logic [6:0]  out_code_w4;
  logic        out_last_w4;
  logic [3:0]  cw_count_w4;
  logic [1:0]  state_dbg_w4;

`ifdef HAMMING_ERR_INJECT_EN
  logic        inj_en;
  logic [2:0]  inj_pos;
`endif

  int n_checks;
  int n_fail;
  logic [6:0] exp_q[$];

  hamming74_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .cw_count  (cw_count),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
`endif
    .state_dbg (state_dbg)
  );

  hamming74_encoder #(.CNT_W(4)) dut_w4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w4),
    .in_data   (in_data),
    .out_valid (out_valid_w4),
    .out_ready (out_ready),
    .out_code  (out_code_w4),
    .out_last  (out_last_w4),
    .cw_count  (cw_count_w4),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
`endif
    .state_dbg (state_dbg_w4)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] syn(input logic [6:0] c);
    logic s0, s1, s2;
    s0 = c[5] ^ c[4] ^ c[3] ^ c[0];
    s1 = c[6] ^ c[5] ^ c[4] ^ c[1];
    s2 = c[6] ^ c[5] ^ c[3] ^ c[2];
    return {s2, s1, s0};
  endfunction

  function automatic logic [6:0] correct(input logic [6:0] c);
    logic [6:0] r;
    r = c;
    case (syn(c))
      3'b001: r[0] = ~r[0];
      3'b010: r[1] = ~r[1];
      3'b100: r[2] = ~r[2];
      3'b101: r[3] = ~r[3];
      3'b011: r[4] = ~r[4];
      3'b111: r[5] = ~r[5];
      3'b110: r[6] = ~r[6];
      default: r = c;
    endcase
    return r;
  endfunction

  // Streams n bytes with out_ready high, checking each codeword's syndrome.
  task automatic run_stream(input int n);
    int  acc;
    bit  done;
    acc  = 0;
    done = 1'b0;
    for (int c = 0; c < 4 * n + 8; c++) begin
      if (!done) begin
        in_valid  = (acc < n);
        in_data   = 8'(acc * 17);
        out_ready = 1'b1;
        #1;
        if (!in_valid && !out_valid) begin
          done = 1'b1;
        end else begin
          if (out_valid && out_ready)
            check("stream_syndrome", 32'(syn(out_code)), 32'h0);
          if (in_valid && in_ready)
            acc++;
          tick();
        end
      end
    end
    if (!done)
      check("stream_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    logic [7:0] seq [3];
    int         bi;
    logic [6:0] exp;

    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
    inj_en    = 1'b0;
    inj_pos   = 3'd7;
`endif

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_last",  32'(out_last),  32'h0);
    check("rst_out_code",  32'(out_code),  32'h00);
    check("rst_cw_count",  32'(cw_count),  32'h0);
    check("rst_state",     32'(state_dbg), 32'h0);

    // Single byte B5 -> 2A then 58
    reset_n   = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB5;
    out_ready = 1'b1;
    #1;
    check("b5_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    #1;
    check("b5_valid_low", 32'(out_valid), 32'h1);
    check("b5_code_low",  32'(out_code),  32'h2A);
    check("b5_last_low",  32'(out_last),  32'h0);
    tick();
    check("b5_code_high", 32'(out_code), 32'h58);
    check("b5_last_high", 32'(out_last), 32'h1);
    tick();
    check("b5_empty", 32'(out_valid), 32'h0);
    check("b5_count", 32'(cw_count),  32'h2);

    // Back-to-back 00, FF, 81 at full rate
    seq = '{8'h00, 8'hFF, 8'h81};
    exp_q.push_back(7'h00);
    exp_q.push_back(7'h00);
    exp_q.push_back(7'h7F);
    exp_q.push_back(7'h7F);
    exp_q.push_back(7'h0D);
    exp_q.push_back(7'h46);
    bi = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid  = (bi < 3);
      in_data   = (bi < 3) ? seq[bi] : 8'h00;
      out_ready = 1'b1;
      #1;
      if (cyc <= 6)
        check("bb_in_ready", 32'(in_ready), 32'((cyc % 2) == 0));
      check("bb_out_valid", 32'(out_valid), 32'((cyc >= 1) && (cyc <= 6)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("bb_extra_code", 32'h1, 32'h0);
        end else begin
          exp = exp_q.pop_front();
          check("bb_code",     32'(out_code),      32'(exp));
          check("bb_syndrome", 32'(syn(out_code)), 32'h0);
          check("bb_last",     32'(out_last),      32'((cyc % 2) == 0));
        end
      end
      if (in_valid && in_ready)
        bi++;
      tick();
    end
    check("bb_drained", 32'(exp_q.size()), 32'h0);
    check("bb_count",   32'(cw_count),      32'h8);

    // Backpressure in LOW for 5 cycles: byte A7 -> 39 then 55
    in_valid  = 1'b1;
    in_data   = 8'hA7;
    out_ready = 1'b0;
    #1;
    check("bp_accept", 32'(in_ready), 32'h1);
    tick();
    in_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_code",  32'(out_code),  32'h39);
      check("bp_hold_last",  32'(out_last),  32'h0);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready",   32'(in_ready),  32'h0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_rel_low", 32'(out_code), 32'h39);
    tick();
    check("bp_rel_high", 32'(out_code), 32'h55);
    check("bp_rel_last", 32'(out_last), 32'h1);
    tick();
    check("bp_empty", 32'(out_valid), 32'h0);
    check("bp_count", 32'(cw_count),  32'd10);

    // Reset mid-byte after accepting 3C
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    out_ready = 1'b0;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    check("mr_low_code", 32'(out_code), 32'h61);
    reset_n = 1'b0;
    tick();
    check("mr_out_valid", 32'(out_valid), 32'h0);
    check("mr_out_last",  32'(out_last),  32'h0);
    check("mr_out_code",  32'(out_code),  32'h00);
    check("mr_cw_count",  32'(cw_count),  32'h0);
    check("mr_in_ready",  32'(in_ready),  32'h0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mr_in_ready_after", 32'(in_ready), 32'h1);
    tick();
    check("mr_no_stale", 32'(out_valid), 32'h0);
    in_valid = 1'b1;
    in_data  = 8'h5B;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    check("mr_next_low", 32'(out_code), 32'h58);
    tick();
    check("mr_next_high", 32'(out_code), 32'h2A);
    check("mr_next_last", 32'(out_last), 32'h1);
    tick();
    check("mr_next_empty", 32'(out_valid), 32'h0);
    check("mr_next_count", 32'(cw_count),  32'h2);

    // Counter wrap on the CNT_W=4 instance
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
    run_stream(8);
    check("wrap_w4_16",  32'(cw_count_w4), 32'h0);
    check("wrap_w16_16", 32'(cw_count),    32'd16);
    in_valid  = 1'b1;
    in_data   = 8'h81;
    out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    check("wrap_low_code", 32'(out_code), 32'h0D);
    tick();
    out_ready = 1'b0;
    #1;
    check("wrap_w4_17",     32'(cw_count_w4), 32'h1);
    check("wrap_w16_17",    32'(cw_count),    32'd17);
    check("wrap_high_code", 32'(out_code),    32'h46);
    out_ready = 1'b1;
    #1;
    tick();
    check("wrap_empty", 32'(out_valid), 32'h0);

`ifdef HAMMING_ERR_INJECT_EN
    // Injection at bit 2 on the low nibble of 0B
    inj_en    = 1'b1;
    inj_pos   = 3'd2;
    in_valid  = 1'b1;
    in_data   = 8'h0B;
    out_ready = 1'b0;
    #1;
    tick();
    inj_en   = 1'b0;
    in_valid = 1'b0;
    #1;
    check("inj_corrupt",   32'(out_code),          32'h5C);
    check("inj_corrected", 32'(correct(out_code)), 32'h58);
    out_ready = 1'b1;
    #1;
    tick();
    check("inj_high_clean", 32'(out_code), 32'h00);
    tick();
    // inj_pos=7 leaves the codeword untouched
    inj_en    = 1'b1;
    inj_pos   = 3'd7;
    in_valid  = 1'b1;
    in_data   = 8'h0B;
    out_ready = 1'b0;
    #1;
    tick();
    in_valid = 1'b0;
    inj_en   = 1'b0;
    #1;
    check("inj_pos7", 32'(out_code), 32'h58);
    out_ready = 1'b1;
    #1;
    tick();
    tick();
    check("inj_empty", 32'(out_valid), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming74_encoder.md
# hamming74_encoder

Streaming Hamming(7,4) encoder for the transmit side of the channel-coding path. It accepts bytes over a valid/ready handshake and splits each byte into two nibbles, low nibble first. Each nibble is emitted as a registered 7-bit codeword whose parity makes the receive-side syndrome (s0 = c5^c4^c3^c0, s1 = c6^c5^c4^c1, s2 = c6^c5^c3^c2) zero. A codeword counter is provided for link statistics. An optional error-injection port supports decoder bring-up.

## Interface
- CNT_W, 16: width of the transferred-codeword counter.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  byte available on in_data.
- in_ready  out  1  encoder can accept a byte this cycle.
- in_data  in  8  payload byte; [3:0] is encoded first, [7:4] second.
- out_valid  out  1  out_code holds a valid codeword.
- out_ready  in  1  downstream accepts out_code this cycle.
- out_code  out  7  codeword; [6:3] data, [2:0] parity.
- out_last  out  1  high while out_code carries the high nibble of a byte.
- cw_count  out  CNT_W  number of codewords transferred, modulo 2^CNT_W.
- inj_en  in  1  error-injection enable. Present only with HAMMING_ERR_INJECT_EN.
- inj_pos  in  3  bit index to flip; 7 means no flip. Present only with HAMMING_ERR_INJECT_EN.

## Operation
- Encode rule for nibble d[3:0]:
  - c[6:3] = d.
  - c0 = d2^d1^d0.
  - c1 = d3^d2^d1.
  - c2 = d3^d2^d0.
- States:
  - EMPTY: nothing held.
  - LOW: out_code holds the low-nibble codeword; the high nibble is held internally.
  - HIGH: out_code holds the high-nibble codeword.
- Transitions:
  - EMPTY, input handshake (in_valid & in_ready) → LOW. Low codeword and high nibble are registered.
  - LOW, output handshake (out_valid & out_ready) → HIGH. High codeword is registered.
  - HIGH, output handshake with no new byte → EMPTY.
  - HIGH, output handshake with a simultaneous input handshake → LOW, using the new byte.
  - Any state without a handshake: hold state and out_code.
- in_ready = (state==EMPTY) | (state==HIGH & out_ready). Combinational from state and out_ready; not dependent on in_valid.
- out_valid = (state != EMPTY).
- out_last = (state == HIGH).
- While out_valid=1 and out_ready=0, out_code and out_last stay stable.
- cw_count increments by 1 on every output handshake and wraps from 2^CNT_W-1 to 0.
- Reset (reset_n=0 at an edge), including mid-byte:
  - state → EMPTY; any pending high nibble is discarded.
  - out_valid=0, out_last=0, out_code=7'h00, cw_count=0.
  - in_ready=0 during the reset cycle.

## Timing
- Latency: a byte accepted at edge N presents its low codeword from cycle N+1.
- The high codeword appears in the cycle after the low codeword's handshake.
- Throughput with out_ready held high: 1 codeword per cycle, 1 byte per 2 cycles, no bubbles.
- Outputs are registered.
- Combinational path exists only for in_ready (from out_ready); no combinational path from in_* to out_*.

## Configuration
- HAMMING_ERR_INJECT_EN defined:
  - inj_en and inj_pos ports exist.
  - When a codeword is loaded into out_code, if inj_en=1 and inj_pos<7, bit inj_pos of that codeword is inverted.
  - inj_en and inj_pos are sampled at that loading edge only.
  - cw_count counts corrupted codewords normally.
- HAMMING_ERR_INJECT_EN undefined:
  - Ports absent; codewords are always clean.
  - No injection logic is synthesized.

## Test plan
- Reset then in_data=8'hB5 with out_ready=1 → out_code 7'h2A (out_last=0), then 7'h58 (out_last=1); cw_count=2.
- Bytes 8'h00, 8'hFF, 8'h81 back-to-back, out_ready=1 → codewords 00,00,7F,7F,0D,46 on consecutive cycles; in_ready high every second cycle; each codeword gives syndrome 000.
- Backpressure: out_ready=0 for 5 cycles during LOW → out_code held at the low codeword, in_ready=0; releasing out_ready resumes with the high codeword; no loss or duplication.
- reset_n=0 in state LOW after accepting 8'h3C → next cycle out_valid=0, cw_count=0; the 0x3 nibble is never emitted; the next byte encodes normally.
- CNT_W=4 with 17 codewords transferred → cw_count wraps to 1.
- With HAMMING_ERR_INJECT_EN, inj_en=1, inj_pos=2, byte 8'h0B → out_code 7'h5C, and the receive-side decoder corrects it back to 7'h58; with inj_pos=7 → 7'h58 unmodified.
